// File: rtl/camera_cfg_pkg.sv
// Shared types and constants for the camera register-table sequencer.
// Contents: widths, the delay-entry marker address, the table entry payload
// and the sequencer state encoding.
package camera_cfg_pkg;

    localparam int unsigned IDX_W   = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ENTRY_W = 16;
    localparam int unsigned TCNT_W  = 16;
    localparam int unsigned RETRY_W = 8;

    // An entry with this address is a pause, not a bus write
    localparam logic [DATA_W-1:0] DELAY_ADDR = 8'hFF;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cfg_entry_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_W_ISSUE,
        S_W_FALL,
        S_W_RISE,
        S_W_CHK,
        S_R_ISSUE,
        S_R_FALL,
        S_R_RISE,
        S_R_CHK,
        S_FAIL,
        S_NEXT,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/camera_cfg_if.sv
// Request/response link between the sequencer and the iic_driver.
// master: sequencer side (drives wr_en/rd_en/addr/wr_data)
// slave : driver side (drives rd_data/work_done/ack)
interface camera_cfg_if;
    import camera_cfg_pkg::*;

    logic              iic_wr_en;
    logic              iic_rd_en;
    logic [DATA_W-1:0] iic_addr;
    logic [DATA_W-1:0] iic_wr_data;
    logic [DATA_W-1:0] iic_rd_data;
    logic              iic_work_done;
    logic              iic_ack;

    modport master (
        output iic_wr_en, iic_rd_en, iic_addr, iic_wr_data,
        input  iic_rd_data, iic_work_done, iic_ack
    );

    modport slave (
        input  iic_wr_en, iic_rd_en, iic_addr, iic_wr_data,
        output iic_rd_data, iic_work_done, iic_ack
    );

endinterface

// File: rtl/camera_cfg_rom.sv
// Constant camera register table, combinational lookup by index.
// Ports: i_idx (table index), o_entry ({addr,data} at that index).
// TABLE_SEL=0 selects the OV7670 init table; TABLE_SEL=1 selects a short
// bring-up table used for link smoke tests. Unlisted indices read as a
// zero-length delay so they never cause bus traffic.
module camera_cfg_rom
    import camera_cfg_pkg::*;
#(
    parameter int unsigned TABLE_SEL = 0
) (
    input  logic [IDX_W-1:0] i_idx,
    output cfg_entry_t       o_entry
);

    logic [ENTRY_W-1:0] w_raw;

    always_comb begin
        w_raw = {DELAY_ADDR, 8'h00};
        if (TABLE_SEL == 1) begin
            case (i_idx)
                8'd0:    w_raw = {8'h12, 8'h80};
                8'd1:    w_raw = {8'h11, 8'h01};
                8'd2:    w_raw = {8'h40, 8'hD0};
                8'd3:    w_raw = {8'hFF, 8'h02};
                8'd4:    w_raw = {8'h3A, 8'h04};
                default: w_raw = {DELAY_ADDR, 8'h00};
            endcase
        end else begin
            case (i_idx)
                8'd0:    w_raw = {8'h12, 8'h80};  // soft reset
                8'd1:    w_raw = {8'hFF, 8'h0A};  // settle after reset
                8'd2:    w_raw = {8'h12, 8'h04};  // RGB output
                8'd3:    w_raw = {8'h11, 8'h01};  // clock prescaler
                8'd4:    w_raw = {8'h0C, 8'h00};
                8'd5:    w_raw = {8'h3E, 8'h00};
                8'd6:    w_raw = {8'h40, 8'hD0};  // RGB565, full range
                8'd7:    w_raw = {8'h3A, 8'h04};
                8'd8:    w_raw = {8'h14, 8'h18};
                8'd9:    w_raw = {8'h4F, 8'hB3};  // colour matrix
                8'd10:   w_raw = {8'h50, 8'hB3};
                8'd11:   w_raw = {8'h51, 8'h00};
                8'd12:   w_raw = {8'h52, 8'h3D};
                8'd13:   w_raw = {8'h53, 8'hA7};
                8'd14:   w_raw = {8'h54, 8'hE4};
                8'd15:   w_raw = {8'h3D, 8'hC0};
                default: w_raw = {DELAY_ADDR, 8'h00};
            endcase
        end
    end

    assign o_entry = cfg_entry_t'(w_raw);

endmodule

// File: rtl/camera_cfg_seq.sv
// Walks the camera register table and issues each write (and optional
// read-back verify) through the iic_driver, with retry and timeout.
// Ports: clk, rst (sync, active high), start pulse, verify_en (sampled at
// start), busy/done/error status, err_index of the failing entry, and the
// iic master link (wr_en/rd_en/addr/wr_data out, rd_data/work_done/ack in).
module camera_cfg_seq
    import camera_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned DELAY_UNIT  = 1024,
    parameter int unsigned TABLE_SEL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             verify_en,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index,
    camera_cfg_if.master     iic
);

    // One extra index bit so idx can reach NUM_REGS=256
    localparam int unsigned IDXC_W = IDX_W + 1;
    localparam int unsigned DCNT_W = $clog2(256 * DELAY_UNIT);

    state_t              r_state, w_nxt_state;
    logic [IDXC_W-1:0]   r_idx, w_nxt_idx;
    logic [RETRY_W-1:0]  r_retry, w_nxt_retry;
    logic [TCNT_W-1:0]   r_tcnt, w_nxt_tcnt;
    logic [DCNT_W-1:0]   r_dcnt, w_nxt_dcnt;
    logic                r_verify, w_nxt_verify;
    logic [DATA_W-1:0]   r_addr, w_nxt_addr;
    logic [DATA_W-1:0]   r_wr_data, w_nxt_wr_data;
    logic [IDX_W-1:0]    r_err_index, w_nxt_err_index;
    logic                r_busy, w_nxt_busy;
    logic                r_done, w_nxt_done;
    logic                r_error, w_nxt_error;
    logic                r_wr_en, w_nxt_wr_en;
    logic                r_rd_en, w_nxt_rd_en;
    cfg_entry_t          w_entry;
    logic                w_timeout;

    camera_cfg_rom #(.TABLE_SEL(TABLE_SEL)) u_rom (
        .i_idx   (r_idx[IDX_W-1:0]),
        .o_entry (w_entry)
    );

    // Counter is cleared at issue, so this is the TIMEOUT_CYC-th wait cycle
    assign w_timeout = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

    // Next-state, datapath and registered-output decode
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_idx       = r_idx;
        w_nxt_retry     = r_retry;
        w_nxt_tcnt      = r_tcnt;
        w_nxt_dcnt      = r_dcnt;
        w_nxt_verify    = r_verify;
        w_nxt_addr      = r_addr;
        w_nxt_wr_data   = r_wr_data;
        w_nxt_err_index = r_err_index;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_nxt_state     = S_FETCH;
                    w_nxt_idx       = '0;
                    w_nxt_retry     = '0;
                    w_nxt_verify    = verify_en;
                    w_nxt_err_index = '0;
                end
            end
            S_FETCH: begin
                if (r_idx == IDXC_W'(NUM_REGS)) begin
                    w_nxt_state = S_DONE;
                end else if (w_entry.addr == DELAY_ADDR) begin
                    if (w_entry.data == '0) begin
                        w_nxt_state = S_NEXT;
                    end else begin
                        w_nxt_dcnt  = DCNT_W'(w_entry.data) * DCNT_W'(DELAY_UNIT) - DCNT_W'(1);
                        w_nxt_state = S_DELAY;
                    end
                end else begin
                    w_nxt_addr    = w_entry.addr;
                    w_nxt_wr_data = w_entry.data;
                    w_nxt_state   = S_W_ISSUE;
                end
            end
            S_W_ISSUE, S_R_ISSUE: begin
                w_nxt_tcnt  = '0;
                w_nxt_state = (r_state == S_W_ISSUE) ? S_W_FALL : S_R_FALL;
            end
            S_W_FALL, S_R_FALL: begin
                w_nxt_tcnt = r_tcnt + TCNT_W'(1);
                if (!iic.iic_work_done) begin
                    w_nxt_state = (r_state == S_W_FALL) ? S_W_RISE : S_R_RISE;
                end else if (w_timeout) begin
                    w_nxt_state = S_FAIL;
                end
            end
            S_W_RISE, S_R_RISE: begin
                w_nxt_tcnt = r_tcnt + TCNT_W'(1);
                if (iic.iic_work_done) begin
                    w_nxt_state = (r_state == S_W_RISE) ? S_W_CHK : S_R_CHK;
                end else if (w_timeout) begin
                    w_nxt_state = S_FAIL;
                end
            end
            S_W_CHK: begin
                if (iic.iic_ack)      w_nxt_state = S_FAIL;
                else if (r_verify)    w_nxt_state = S_R_ISSUE;
                else                  w_nxt_state = S_NEXT;
            end
            S_R_CHK: begin
                if (iic.iic_ack || (iic.iic_rd_data != r_wr_data)) w_nxt_state = S_FAIL;
                else                                               w_nxt_state = S_NEXT;
            end
            S_FAIL: begin
                // A retry redoes the whole entry, write first
                if (r_retry < RETRY_W'(MAX_RETRY)) begin
                    w_nxt_retry = r_retry + RETRY_W'(1);
                    w_nxt_state = S_W_ISSUE;
                end else begin
                    w_nxt_err_index = r_idx[IDX_W-1:0];
                    w_nxt_state     = S_ERROR;
                end
            end
            S_NEXT: begin
                w_nxt_idx   = r_idx + IDXC_W'(1);
                w_nxt_retry = '0;
                w_nxt_state = S_FETCH;
            end
            S_DELAY: begin
                if (r_dcnt == '0) w_nxt_state = S_NEXT;
                else              w_nxt_dcnt  = r_dcnt - DCNT_W'(1);
            end
            default: w_nxt_state = S_IDLE;
        endcase

        w_nxt_busy  = !((w_nxt_state == S_IDLE) || (w_nxt_state == S_DONE) ||
                        (w_nxt_state == S_ERROR));
        w_nxt_done  = (w_nxt_state == S_DONE);
        w_nxt_error = (w_nxt_state == S_ERROR);
        w_nxt_wr_en = (w_nxt_state == S_W_ISSUE);
        w_nxt_rd_en = (w_nxt_state == S_R_ISSUE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_retry     <= '0;
            r_tcnt      <= '0;
            r_dcnt      <= '0;
            r_verify    <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_err_index <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_retry     <= w_nxt_retry;
            r_tcnt      <= w_nxt_tcnt;
            r_dcnt      <= w_nxt_dcnt;
            r_verify    <= w_nxt_verify;
            r_addr      <= w_nxt_addr;
            r_wr_data   <= w_nxt_wr_data;
            r_err_index <= w_nxt_err_index;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_error     <= w_nxt_error;
            r_wr_en     <= w_nxt_wr_en;
            r_rd_en     <= w_nxt_rd_en;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign err_index       = r_err_index;
    assign iic.iic_wr_en   = r_wr_en;
    assign iic.iic_rd_en   = r_rd_en;
    assign iic.iic_addr    = r_addr;
    assign iic.iic_wr_data = r_wr_data;

endmodule

// File: tb/tb_camera_cfg_seq.sv
// Bench for camera_cfg_seq using the bring-up table
// {12,80},{11,01},{40,D0},{FF,02},{3A,04}, an iic_driver model with a
// 40-cycle op and a register-file slave with programmable NACK/corruption.
module tb_camera_cfg_seq;
    import camera_cfg_pkg::*;

    localparam int unsigned NREG       = 5;
    localparam int unsigned OP_CYC     = 40;
    localparam int unsigned TO_CYC     = 4096;
    localparam int unsigned DUNIT      = 1024;
    localparam int unsigned MAXR       = 3;
    localparam int unsigned RUN_BUDGET = 25000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       verify_en = 1'b0;
    logic       busy, done, error;
    logic [7:0] err_index;

    camera_cfg_if iic_bus ();

    camera_cfg_seq #(
        .NUM_REGS(NREG), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TO_CYC),
        .DELAY_UNIT(DUNIT), .TABLE_SEL(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .verify_en(verify_en),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .iic(iic_bus)
    );

    always #5 clk = ~clk;

    // Bench's own copy of the table
    logic [7:0] tbl_a [NREG] = '{8'h12, 8'h11, 8'h40, 8'hFF, 8'h3A};
    logic [7:0] tbl_d [NREG] = '{8'h80, 8'h01, 8'hD0, 8'h02, 8'h04};

    // Slave behaviour knobs (written only by the test process)
    int         nack_cfg [256];
    bit         bad_rd   [256];
    bit         hang = 1'b0;

    // Driver/slave model state (written only by the model process)
    logic [7:0] regs   [256];
    int         wr_att [256];
    int         n_wr = 0, n_rd = 0, cyc = 0;
    int         both_err = 0, mid_err = 0, hold_err = 0;
    int         t_wr40 = 0, t_wr3a = 0;
    logic       drv_active = 1'b0, drv_rd = 1'b0;
    int         drv_cnt = 0;
    logic [7:0] drv_addr = 8'h00, drv_data = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            iic_bus.iic_work_done <= 1'b1;
            iic_bus.iic_ack       <= 1'b0;
            iic_bus.iic_rd_data   <= 8'h00;
            drv_active <= 1'b0;
            drv_cnt    <= 0;
            n_wr       <= 0;
            n_rd       <= 0;
            for (int i = 0; i < 256; i++) begin
                regs[i]   <= 8'h00;
                wr_att[i] <= 0;
            end
        end else if (iic_bus.iic_wr_en || iic_bus.iic_rd_en) begin
            if (iic_bus.iic_wr_en && iic_bus.iic_rd_en) both_err <= both_err + 1;
            if ((drv_active || !iic_bus.iic_work_done) && !hang) mid_err <= mid_err + 1;
            drv_active <= 1'b1;
            drv_rd     <= iic_bus.iic_rd_en;
            drv_cnt    <= OP_CYC;
            drv_addr   <= iic_bus.iic_addr;
            drv_data   <= iic_bus.iic_wr_data;
            iic_bus.iic_work_done <= 1'b0;
            if (iic_bus.iic_rd_en) n_rd <= n_rd + 1;
            else begin
                n_wr <= n_wr + 1;
                wr_att[iic_bus.iic_addr] <= wr_att[iic_bus.iic_addr] + 1;
            end
            if (iic_bus.iic_wr_en && iic_bus.iic_addr == 8'h40) t_wr40 <= cyc;
            if (iic_bus.iic_wr_en && iic_bus.iic_addr == 8'h3A) t_wr3a <= cyc;
        end else if (drv_active) begin
            if (iic_bus.iic_addr != drv_addr || iic_bus.iic_wr_data != drv_data)
                hold_err <= hold_err + 1;
            if (!hang) begin
                if (drv_cnt == 1) begin
                    drv_active <= 1'b0;
                    iic_bus.iic_work_done <= 1'b1;
                    if (drv_rd) begin
                        iic_bus.iic_ack     <= 1'b0;
                        iic_bus.iic_rd_data <= bad_rd[drv_addr] ? 8'h00 : regs[drv_addr];
                    end else if (wr_att[drv_addr] <= nack_cfg[drv_addr]) begin
                        iic_bus.iic_ack <= 1'b1;
                    end else begin
                        iic_bus.iic_ack <= 1'b0;
                        regs[drv_addr]  <= drv_data;
                    end
                end
                drv_cnt <= drv_cnt - 1;
            end
        end
    end

    int         n_tests = 0, n_fail = 0;
    logic [7:0] exp_reg [256];

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    task automatic set_cfg(input int n11, input bit b11, input bit h);
        for (int i = 0; i < 256; i++) begin
            nack_cfg[i] = 0;
            bad_rd[i]   = 1'b0;
        end
        nack_cfg[8'h11] = n11;
        bad_rd[8'h11]   = b11;
        hang            = h;
    endtask

    // Reference: each bus entry gets up to MAXR+1 attempts; an attempt is a
    // write (NACKed while the address still owes NACKs), then with verify a
    // read that fails if the slave corrupts it. Hang fails every attempt.
    task automatic model(input bit v, output bit e_done, output bit e_err,
                         output int e_idx, output int e_wr, output int e_rd);
        int  owed;
        bit  ok;
        e_wr = 0; e_rd = 0; e_err = 1'b0; e_idx = 0;
        for (int i = 0; i < 256; i++) exp_reg[i] = 8'h00;
        for (int i = 0; i < int'(NREG); i++) begin
            if (tbl_a[i] == 8'hFF) continue;
            owed = nack_cfg[tbl_a[i]];
            ok   = 1'b0;
            for (int att = 0; att <= int'(MAXR) && !ok; att++) begin
                e_wr++;
                if (hang) continue;
                if (owed > 0) begin owed--; continue; end
                exp_reg[tbl_a[i]] = tbl_d[i];
                if (!v) ok = 1'b1;
                else begin
                    e_rd++;
                    if (!bad_rd[tbl_a[i]]) ok = 1'b1;
                end
            end
            if (!ok) begin e_err = 1'b1; e_idx = i; break; end
        end
        e_done = !e_err;
    endtask

    task automatic run_case(input string nm, input bit v, input bit do_rst,
                            input bit e_done, input bit e_err, input int e_idx,
                            input int e_wr, input int e_rd, output int cycles);
        int n, wr0, rd0;
        bit fin;
        if (do_rst) begin
            @(negedge clk); rst = 1'b1; start = 1'b0;
            @(negedge clk); rst = 1'b0;
            chk({nm, " reset outputs"},
                int'({busy, done, error, err_index, iic_bus.iic_wr_en, iic_bus.iic_rd_en,
                      iic_bus.iic_addr, iic_bus.iic_wr_data}), 0);
        end
        wr0 = n_wr; rd0 = n_rd;
        @(negedge clk); start = 1'b1; verify_en = v;
        @(negedge clk); start = 1'b0; verify_en = ~v;
        chk({nm, " busy after start"}, int'(busy), 1);
        chk({nm, " status cleared"}, int'({done, error}), 0);
        n = 0; fin = 1'b0;
        while (!fin && n < int'(RUN_BUDGET)) begin
            @(negedge clk);
            n++;
            start = (n == 20) && busy;
            fin = done || error;
        end
        start = 1'b0;
        cycles = n;
        chk({nm, " finished in budget"}, int'(fin), 1);
        chk({nm, " done"}, int'(done), int'(e_done));
        chk({nm, " error"}, int'(error), int'(e_err));
        chk({nm, " busy low"}, int'(busy), 0);
        if (e_err) chk({nm, " err_index"}, int'(err_index), e_idx);
        chk({nm, " write ops"}, n_wr - wr0, e_wr);
        chk({nm, " read ops"}, n_rd - rd0, e_rd);
        for (int i = 0; i < int'(NREG); i++)
            if (tbl_a[i] != 8'hFF)
                chk($sformatf("%s reg %0h", nm, tbl_a[i]), int'(regs[tbl_a[i]]),
                    int'(exp_reg[tbl_a[i]]));
    endtask

    typedef struct {
        bit v; int nack11; bit bad11; bit hang;
        bit e_done; bit e_err; int e_idx; int e_wr; int e_rd;
    } vec_t;

    initial begin
        vec_t vecs [7];
        bit   m_done, m_err;
        int   m_idx, m_wr, m_rd, cyc_used, k;
        bit   rv;

        vecs[0] = '{v:0, nack11:0,   bad11:0, hang:0, e_done:1, e_err:0, e_idx:0, e_wr:4, e_rd:0};
        vecs[1] = '{v:1, nack11:0,   bad11:0, hang:0, e_done:1, e_err:0, e_idx:0, e_wr:4, e_rd:4};
        vecs[2] = '{v:0, nack11:2,   bad11:0, hang:0, e_done:1, e_err:0, e_idx:0, e_wr:6, e_rd:0};
        vecs[3] = '{v:0, nack11:255, bad11:0, hang:0, e_done:0, e_err:1, e_idx:1, e_wr:5, e_rd:0};
        vecs[4] = '{v:1, nack11:0,   bad11:1, hang:0, e_done:0, e_err:1, e_idx:1, e_wr:5, e_rd:5};
        vecs[5] = '{v:0, nack11:0,   bad11:0, hang:1, e_done:0, e_err:1, e_idx:0, e_wr:4, e_rd:0};
        vecs[6] = '{v:1, nack11:2,   bad11:0, hang:0, e_done:1, e_err:0, e_idx:0, e_wr:6, e_rd:4};

        set_cfg(0, 1'b0, 1'b0);

        // start coinciding with rst is dropped
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        chk("rst+start busy", int'(busy), 0);
        @(negedge clk);
        chk("rst+start still idle", int'({busy, done, error}), 0);

        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].nack11, vecs[i].bad11, vecs[i].hang);
            model(vecs[i].v, m_done, m_err, m_idx, m_wr, m_rd);
            run_case($sformatf("vec%0d", i), vecs[i].v, 1'b1, vecs[i].e_done,
                     vecs[i].e_err, vecs[i].e_idx, vecs[i].e_wr, vecs[i].e_rd, cyc_used);
            if (vecs[i].hang)
                chk("hang run length in range",
                    int'(cyc_used >= 4 * int'(TO_CYC) && cyc_used <= 4 * int'(TO_CYC) + 64), 1);
        end

        // Delay entry: gap between the writes around {FF,02}
        set_cfg(0, 1'b0, 1'b0);
        model(1'b0, m_done, m_err, m_idx, m_wr, m_rd);
        run_case("delay", 1'b0, 1'b1, 1'b1, 1'b0, 0, 4, 0, cyc_used);
        chk($sformatf("delay gap %0d in range", t_wr3a - t_wr40),
            int'((t_wr3a - t_wr40) >= 2 * int'(DUNIT) + int'(OP_CYC) &&
                 (t_wr3a - t_wr40) <= 2 * int'(DUNIT) + int'(OP_CYC) + 16), 1);

        // Restart from DONE without reset clears done and reruns the table
        run_case("restart", 1'b0, 1'b0, 1'b1, 1'b0, 0, 4, 0, cyc_used);

        // Reset in the middle of a write
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1; verify_en = 1'b0;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!iic_bus.iic_wr_en && k < 100) begin @(negedge clk); k++; end
        chk("midrst saw write", int'(iic_bus.iic_wr_en), 1);
        repeat (10) @(negedge clk);
        chk("midrst driver mid-op", int'(iic_bus.iic_work_done), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst outputs zero",
            int'({busy, done, error, err_index, iic_bus.iic_wr_en, iic_bus.iic_rd_en,
                  iic_bus.iic_addr, iic_bus.iic_wr_data}), 0);
        rst = 1'b0;
        run_case("after midrst", 1'b0, 1'b0, 1'b1, 1'b0, 0, 4, 0, cyc_used);

        // Randomised fault mixes against the reference model
        for (int r = 0; r < 6; r++) begin
            rv = 1'(($urandom_range(0, 1)));
            set_cfg(0, 1'b0, 1'b0);
            for (int i = 0; i < int'(NREG); i++) begin
                if (tbl_a[i] == 8'hFF) continue;
                nack_cfg[tbl_a[i]] = int'($urandom_range(0, 4));
                bad_rd[tbl_a[i]]   = ($urandom_range(0, 5) == 0);
            end
            model(rv, m_done, m_err, m_idx, m_wr, m_rd);
            run_case($sformatf("rand%0d", r), rv, 1'b1, m_done, m_err, m_idx, m_wr, m_rd,
                     cyc_used);
        end

        chk("wr_en and rd_en together", both_err, 0);
        chk("request while driver mid-op", mid_err, 0);
        chk("addr/data held during op", hold_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
